// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types for the data-memory line responder.
//   LINE_W        - line width in bits (4 x 32-bit words, word0 in [31:0])
//   REQ_ADDR_W    - byte-address width carried in a captured request
//   CNT_W         - width of the latency counter (LATENCY is 1..255)
//   line_t        - one memory line
//   dmem_state_e  - responder FSM states
//   dmem_req_t    - request captured on the accept handshake
package dmem_pkg;

    localparam int LINE_W     = 128;
    localparam int REQ_ADDR_W = 32;
    localparam int CNT_W      = 8;

    typedef logic [LINE_W-1:0] line_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    typedef struct packed {
        logic                  write;
        logic [REQ_ADDR_W-1:0] addr;
        line_t                 wdata;
    } dmem_req_t;

endpackage

// File: rtl/dmem_line_array.sv
// dmem_line_array: backing store for the line responder.
// Synchronous write, registered read. The read register is the responder's
// resp_rdata; it is cleared by reset and by write or rejected accesses.
// memArray is deliberately left without reset so preloaded contents survive.
//   clock  - rising-edge clock
//   reset  - synchronous active-high, clears only the read register
//   wr_en  - write wdata into memArray[idx]; read register goes to 0
//   rd_en  - load memArray[idx] into the read register
//   clr    - force the read register to 0 (rejected access)
//   idx    - line index (DEPTH is a power of two, so the index wraps)
//   wdata  - line to write
//   rdata  - registered read line
module dmem_line_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic             clr,
    input  logic [IDX_W-1:0] idx,
    input  line_t            wdata,
    output line_t            rdata
);

    line_t memArray [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            memArray[idx] <= wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rdata <= '0;
        end else if (rd_en) begin
            rdata <= memArray[idx];
        end else if (wr_en || clr) begin
            rdata <= '0;
        end
    end

endmodule

// File: rtl/dmem_line_responder.sv
// dmem_line_responder: responder end of the data-cache line interface.
// Accepts one line read/write at a time and answers after a fixed LATENCY,
// modelling main memory. Storage lives in the main_memory sub-instance
// (main_memory.memArray), which benches preload by hierarchical reference.
//
// Optional feature macro: DMEM_ADDR_CHECK_EN
//   defined   - misaligned (addr[3:0] != 0) or out-of-range (addr >= DEPTH*16)
//               requests answer with resp_err=1, no array write, rdata 0
//   undefined - offset bits ignored, index wraps modulo DEPTH, resp_err=0
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. valid, once raised by the responder, stays high with stable
// payload until the matching ready; the requester may drop req_valid freely.
//
// Ports:
//   clock, reset         - rising-edge clock, synchronous active-high reset
//   req_valid/req_ready  - request handshake (req_ready decoded from state)
//   req_write            - 1 = line write, 0 = line read
//   req_addr             - byte address of the line
//   req_wdata            - write line, word0 in [31:0]
//   resp_valid/resp_ready- response handshake
//   resp_rdata           - read line (0 for writes and rejected requests)
//   resp_err             - request rejected by the address check
module dmem_line_responder #(
    parameter int LINE_W  = 128,
    parameter int DEPTH   = 1024,
    parameter int ADDR_W  = 32,
    parameter int LATENCY = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LINE_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [LINE_W-1:0] resp_rdata,
    output logic              resp_err
);

    import dmem_pkg::*;

    localparam int IDX_W = $clog2(DEPTH);

    dmem_state_e      state;
    logic [CNT_W-1:0] cnt;
    dmem_req_t        cur;
    logic             addr_err;
    logic             fire;
    logic             arr_wr_en;
    logic             arr_rd_en;
    logic             arr_clr;
    logic [IDX_W-1:0] idx;

    assign req_ready = (state == IDLE);
    assign idx       = cur.addr[IDX_W+3:4];

`ifdef DMEM_ADDR_CHECK_EN
    assign addr_err = (cur.addr[3:0] != 4'd0) || ((cur.addr >> (IDX_W + 4)) != '0);
`else
    assign addr_err = 1'b0;
    logic unused_addr_bits;
    assign unused_addr_bits = ^{cur.addr[3:0], cur.addr[REQ_ADDR_W-1:IDX_W+4]};
`endif

    // The access happens on the WAIT-to-RESP edge. Gating with reset keeps a
    // write that coincides with reset from reaching the array.
    assign fire      = (state == WAIT) && (cnt == '0);
    assign arr_wr_en = fire && cur.write  && !addr_err && !reset;
    assign arr_rd_en = fire && !cur.write && !addr_err && !reset;
    assign arr_clr   = fire && addr_err;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            cur        <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        cur.write <= req_write;
                        cur.addr  <= REQ_ADDR_W'(req_addr);
                        cur.wdata <= req_wdata;
                        // LATENCY-1 so the response appears LATENCY edges
                        // after the accept edge, counting the exit from WAIT.
                        cnt       <= CNT_W'(LATENCY - 1);
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        resp_valid <= 1'b1;
                        resp_err   <= addr_err;
                        state      <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_err   <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    dmem_line_array #(
        .DEPTH (DEPTH)
    ) main_memory (
        .clock (clock),
        .reset (reset),
        .wr_en (arr_wr_en),
        .rd_en (arr_rd_en),
        .clr   (arr_clr),
        .idx   (idx),
        .wdata (cur.wdata),
        .rdata (resp_rdata)
    );

endmodule
